// File: rtl/clock_set_ctrl.sv
// clock_set_ctrl
//   Front-panel controller for the digital clock's time-keeper. It debounces
//   three active-low push-buttons, runs the RUN/SET_MIN/SET_HOUR/SET_DAY
//   mode machine, and drives the time-keeper's level adjust requests plus a
//   blink enable for the field being set.
//
// Ports
//   CLK        in   system clock, all logic on posedge
//   Rst        in   synchronous active-high reset
//   KeyMode    in   raw mode button, active-low, asynchronous
//   KeyInc     in   raw increment button, active-low, asynchronous
//   KeyDisp    in   raw display-select button, active-low, asynchronous
//   DispDay    out  high selects day display
//   AdjustMin  out  level request to increment minutes
//   AdjustHour out  level request to increment hours
//   AdjustDay  out  level request to increment day
//   Mode       out  0 RUN, 1 SET_MIN, 2 SET_HOUR, 3 SET_DAY
//   Blink      out  blink enable for the field being set, 0 in RUN
module clock_set_ctrl #(
  parameter int unsigned DEB_CYC     = 1_000_000,
  parameter int unsigned TIMEOUT_CYC = 500_000_000,
  parameter int unsigned BLINK_CYC   = 12_500_000
) (
  input  logic       CLK,
  input  logic       Rst,
  input  logic       KeyMode,
  input  logic       KeyInc,
  input  logic       KeyDisp,
  output logic       DispDay,
  output logic       AdjustMin,
  output logic       AdjustHour,
  output logic       AdjustDay,
  output logic [1:0] Mode,
  output logic       Blink
);

  localparam int unsigned DW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam int unsigned TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam int unsigned BW = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;

  localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYC - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [BW-1:0] BL_LAST  = BW'(BLINK_CYC - 1);

  localparam int unsigned K_MODE = 0;
  localparam int unsigned K_INC  = 1;
  localparam int unsigned K_DISP = 2;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    SET_MIN  = 2'd1,
    SET_HOUR = 2'd2,
    SET_DAY  = 2'd3
  } mode_e;

  // ---------------------------------------------------------------------
  // Key conditioning: 2-flop sync, debounce counter, registered press pulse
  // ---------------------------------------------------------------------
  logic [2:0]    key_raw;
  logic [2:0]    sync1_q, sync2_q;
  logic [2:0]    deb_q, deb_d;
  logic [2:0]    press_q, press_d;
  logic [DW-1:0] deb_cnt_q [3];
  logic [DW-1:0] deb_cnt_d [3];

  assign key_raw = {KeyDisp, KeyInc, KeyMode};

  // The press pulse is registered alongside the debounced level, so it is
  // high in the first cycle the debounced level reads 0.
  always_comb begin
    deb_d   = deb_q;
    press_d = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      deb_cnt_d[k] = '0;
      if (sync2_q[k] != deb_q[k]) begin
        if (deb_cnt_q[k] == DEB_LAST) begin
          deb_d[k]   = sync2_q[k];
          press_d[k] = ~sync2_q[k];
        end else begin
          deb_cnt_d[k] = deb_cnt_q[k] + DW'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      sync1_q <= '1;
      sync2_q <= '1;
      deb_q   <= '1;
      press_q <= '0;
      for (int unsigned k = 0; k < 3; k++) deb_cnt_q[k] <= '0;
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      deb_q   <= deb_d;
      press_q <= press_d;
      for (int unsigned k = 0; k < 3; k++) deb_cnt_q[k] <= deb_cnt_d[k];
    end
  end

  // ---------------------------------------------------------------------
  // Mode FSM, idle timeout, arming, display toggle, blink
  // ---------------------------------------------------------------------
  mode_e         state_q, state_d;
  logic [TW-1:0] idle_q, idle_d;
  logic [BW-1:0] blink_cnt_q, blink_cnt_d;
  logic          arm_q, arm_d;
  logic          toggle_q, toggle_d;
  logic          blink_d;
  logic          adj_min_d, adj_hour_d, adj_day_d, disp_day_d;
  logic          inc_held;
  logic          mode_chg;
  logic          adj_ok;

  assign inc_held = ~deb_q[K_INC];

  always_comb begin
    state_d     = state_q;
    idle_d      = idle_q;
    arm_d       = arm_q;
    toggle_d    = toggle_q;
    blink_cnt_d = blink_cnt_q;
    blink_d     = Blink;

    // A mode press outranks the timeout; it also clears the idle counter.
    if (press_q[K_MODE]) begin
      case (state_q)
        RUN:      state_d = SET_MIN;
        SET_MIN:  state_d = SET_HOUR;
        SET_HOUR: state_d = SET_DAY;
        SET_DAY:  state_d = RUN;
      endcase
    end else if (state_q != RUN && idle_q == TO_LAST) begin
      state_d = RUN;
    end
    mode_chg = (state_d != state_q);

    if ((|press_q) || inc_held || state_q == RUN) begin
      idle_d = '0;
    end else if (idle_q != '1) begin
      idle_d = idle_q + TW'(1);
    end

    // Arm only after the increment key has been seen released in this mode.
    if (mode_chg) begin
      arm_d = 1'b0;
    end else if (!inc_held) begin
      arm_d = 1'b1;
    end

    if (press_q[K_DISP] && state_q == RUN) begin
      toggle_d = ~toggle_q;
    end

    if (mode_chg || state_d == RUN) begin
      blink_cnt_d = '0;
      blink_d     = 1'b0;
    end else if (blink_cnt_q == BL_LAST) begin
      blink_cnt_d = '0;
      blink_d     = ~Blink;
    end else begin
      blink_cnt_d = blink_cnt_q + BW'(1);
    end

    adj_ok     = arm_d & inc_held;
    adj_min_d  = (state_d == SET_MIN)  & adj_ok;
    adj_hour_d = (state_d == SET_HOUR) & adj_ok;
    adj_day_d  = (state_d == SET_DAY)  & adj_ok;

    case (state_d)
      RUN:     disp_day_d = toggle_d;
      SET_DAY: disp_day_d = 1'b1;
      default: disp_day_d = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (Rst) begin
      state_q     <= RUN;
      idle_q      <= '0;
      arm_q       <= 1'b0;
      toggle_q    <= 1'b0;
      blink_cnt_q <= '0;
      Blink       <= 1'b0;
      AdjustMin   <= 1'b0;
      AdjustHour  <= 1'b0;
      AdjustDay   <= 1'b0;
      DispDay     <= 1'b0;
    end else begin
      state_q     <= state_d;
      idle_q      <= idle_d;
      arm_q       <= arm_d;
      toggle_q    <= toggle_d;
      blink_cnt_q <= blink_cnt_d;
      Blink       <= blink_d;
      AdjustMin   <= adj_min_d;
      AdjustHour  <= adj_hour_d;
      AdjustDay   <= adj_day_d;
      DispDay     <= disp_day_d;
    end
  end

  assign Mode = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with DEB_CYC=4, TIMEOUT_CYC=100,
// BLINK_CYC=8. A raw key change driven just after edge N is seen on the
// debounced level at edge N+6 and on the registered outputs at edge N+7.
module tb_clock_set_ctrl;

  logic       CLK = 1'b0;
  logic       Rst = 1'b1;
  logic       KeyMode = 1'b0;
  logic       KeyInc = 1'b0;
  logic       KeyDisp = 1'b0;
  logic       DispDay, AdjustMin, AdjustHour, AdjustDay, Blink;
  logic [1:0] Mode;

  always #5 CLK = ~CLK;

  clock_set_ctrl #(
    .DEB_CYC    (4),
    .TIMEOUT_CYC(100),
    .BLINK_CYC  (8)
  ) dut (
    .CLK       (CLK),
    .Rst       (Rst),
    .KeyMode   (KeyMode),
    .KeyInc    (KeyInc),
    .KeyDisp   (KeyDisp),
    .DispDay   (DispDay),
    .AdjustMin (AdjustMin),
    .AdjustHour(AdjustHour),
    .AdjustDay (AdjustDay),
    .Mode      (Mode),
    .Blink     (Blink)
  );

  // Output vector: {Mode[1:0], DispDay, AdjustMin, AdjustHour, AdjustDay, Blink}
  localparam logic [6:0] M_ALL = 7'h7F;
  localparam logic [6:0] M_NB  = 7'h7E;

  typedef struct {
    string      tag;
    logic [6:0] mask;
    logic [6:0] exp;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_pass  = 0;
  int unsigned n_fail  = 0;
  int unsigned n_total = 0;

  function automatic logic [6:0] vec(input logic [1:0] m, input logic d,
                                     input logic am, input logic ah,
                                     input logic ad, input logic b);
    return {m, d, am, ah, ad, b};
  endfunction

  task automatic tick(input int unsigned n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [6:0] mask,
                            input logic [6:0] exp);
    exp_t e;
    e.tag  = tag;
    e.mask = mask;
    e.exp  = exp & mask;
    sb.push_back(e);
  endtask

  task automatic check_out();
    exp_t       e;
    logic [6:0] obs;
    obs = {Mode, DispDay, AdjustMin, AdjustHour, AdjustDay, Blink};
    n_total++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty observed=%b expected=<entry>", obs);
    end else begin
      e = sb.pop_front();
      assert ((obs & e.mask) === e.exp) n_pass++;
      else begin
        n_fail++;
        $error("FAIL %s observed=%b expected=%b", e.tag, obs & e.mask, e.exp);
      end
    end
  endtask

  // Queue the expectation, let n edges pass, then compare.
  task automatic step(input string tag, input logic [6:0] mask,
                      input logic [6:0] exp, input int unsigned n);
    expect_out(tag, mask, exp);
    tick(n);
    check_out();
  endtask

  initial begin
    // Reset with all keys held low.
    step("reset_state", M_ALL, vec(2'd0, 0, 0, 0, 0, 0), 3);
    Rst = 1'b0;
    // Keys stay low for only 3 cycles after reset: must not be accepted.
    tick(3);
    KeyMode = 1'b1; KeyInc = 1'b1; KeyDisp = 1'b1;
    step("no_press_after_reset", M_ALL, vec(2'd0, 0, 0, 0, 0, 0), 12);

    // KeyMode bounce 0/1/0 with 2-cycle glitches, then held low.
    KeyMode = 1'b0; tick(2);
    KeyMode = 1'b1; tick(2);
    KeyMode = 1'b0;
    step("mode_before_accept", M_ALL, vec(2'd0, 0, 0, 0, 0, 0), 6);
    step("mode_enter_setmin",  M_ALL, vec(2'd1, 0, 0, 0, 0, 0), 1);
    step("blink_low_7",        M_ALL, vec(2'd1, 0, 0, 0, 0, 0), 7);
    step("blink_rise_8",       M_ALL, vec(2'd1, 0, 0, 0, 0, 1), 1);
    step("blink_high_15",      M_ALL, vec(2'd1, 0, 0, 0, 0, 1), 7);
    step("blink_fall_16",      M_ALL, vec(2'd1, 0, 0, 0, 0, 0), 1);

    // SET_MIN: hold KeyInc, then release.
    KeyMode = 1'b1; KeyInc = 1'b0;
    step("adjmin_not_yet",   M_NB, vec(2'd1, 0, 0, 0, 0, 0), 6);
    step("adjmin_rise",      M_NB, vec(2'd1, 0, 1, 0, 0, 0), 1);
    step("adjmin_hold",      M_NB, vec(2'd1, 0, 1, 0, 0, 0), 10);
    KeyInc = 1'b1;
    step("adjmin_still",     M_NB, vec(2'd1, 0, 1, 0, 0, 0), 6);
    step("adjmin_fall",      M_NB, vec(2'd1, 0, 0, 0, 0, 0), 1);

    // Hold KeyInc across SET_MIN -> SET_HOUR.
    KeyInc = 1'b0;
    step("adjmin_again",     M_NB, vec(2'd1, 0, 1, 0, 0, 0), 7);
    KeyMode = 1'b0;
    step("adjmin_pre_mode",  M_NB, vec(2'd1, 0, 1, 0, 0, 0), 6);
    step("mode2_adj_drop",   M_NB, vec(2'd2, 0, 0, 0, 0, 0), 1);
    step("adjhour_unarmed",  M_NB, vec(2'd2, 0, 0, 0, 0, 0), 10);
    KeyInc = 1'b1; KeyMode = 1'b1;
    step("adjhour_released", M_NB, vec(2'd2, 0, 0, 0, 0, 0), 7);
    KeyInc = 1'b0;
    step("adjhour_not_yet",  M_NB, vec(2'd2, 0, 0, 0, 0, 0), 6);
    step("adjhour_rise",     M_NB, vec(2'd2, 0, 0, 1, 0, 0), 1);
    KeyInc = 1'b1;
    step("adjhour_fall",     M_NB, vec(2'd2, 0, 0, 0, 0, 0), 7);

    // Idle timeout from SET_HOUR: debounced KeyInc rose 6 edges after the
    // release, timeout edge is 100 edges after that.
    step("timeout_not_yet",  M_NB,  vec(2'd2, 0, 0, 0, 0, 0), 98);
    step("timeout_to_run",   M_ALL, vec(2'd0, 0, 0, 0, 0, 0), 1);

    // Display toggle in RUN, retained across set modes.
    KeyDisp = 1'b0;
    step("disp_toggle_on",   M_ALL, vec(2'd0, 1, 0, 0, 0, 0), 7);
    KeyDisp = 1'b1; tick(7);
    KeyMode = 1'b0;
    step("setmin_disp0",     M_NB,  vec(2'd1, 0, 0, 0, 0, 0), 7);
    KeyMode = 1'b1; tick(7);
    KeyDisp = 1'b0;
    step("disp_ignored_set", M_NB,  vec(2'd1, 0, 0, 0, 0, 0), 7);
    KeyDisp = 1'b1; tick(7);
    KeyMode = 1'b0;
    step("sethour_disp0",    M_NB,  vec(2'd2, 0, 0, 0, 0, 0), 7);
    KeyMode = 1'b1; tick(7);
    KeyMode = 1'b0;
    step("setday_disp1",     M_NB,  vec(2'd3, 1, 0, 0, 0, 0), 7);
    KeyMode = 1'b1; tick(7);
    KeyInc = 1'b0;
    step("adjday_rise",      M_NB,  vec(2'd3, 1, 0, 0, 1, 0), 7);
    KeyInc = 1'b1;
    step("adjday_fall",      M_NB,  vec(2'd3, 1, 0, 0, 0, 0), 7);
    KeyMode = 1'b0;
    step("run_disp_kept",    M_ALL, vec(2'd0, 1, 0, 0, 0, 0), 7);
    KeyMode = 1'b1; tick(7);

    // Reset in the middle of an adjust.
    KeyMode = 1'b0;
    step("reenter_setmin",   M_NB,  vec(2'd1, 0, 0, 0, 0, 0), 7);
    KeyMode = 1'b1; tick(7);
    KeyInc = 1'b0;
    step("adjmin_pre_rst",   M_NB,  vec(2'd1, 0, 1, 0, 0, 0), 7);
    Rst = 1'b1; KeyInc = 1'b1;
    step("reset_mid_adjust", M_ALL, vec(2'd0, 0, 0, 0, 0, 0), 1);
    tick(2);
    Rst = 1'b0;
    step("idle_after_reset", M_ALL, vec(2'd0, 0, 0, 0, 0, 0), 20);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
